// File: rtl/bitcount_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bitcount_ctrl
// Description : Sequencing controller for the bit-counter datapath. Accepts
//               LOAD / RUN_UP / RUN_DOWN / NOP commands over valid/ready,
//               drives the counter enable, direction and parallel-load
//               controls, paces advances with a prescaler and stops a run
//               when the counter reaches the commanded target or on abort.
//               Optional macro BITCOUNT_CTRL_STEPCNT_EN adds a 'steps' output
//               reporting the number of advances made by the last run.
// Revision    : 1.0 - initial release
// ============================================================================
module bitcount_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1,
  parameter int PRE_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             cnt_ld,
  output logic [WIDTH-1:0] cnt_ld_val,
  output logic             busy,
  output logic             done,
  output logic             aborted
`ifdef BITCOUNT_CTRL_STEPCNT_EN
  ,
  output logic [WIDTH:0]   steps
`endif
);

  localparam logic [1:0] c_op_load = 2'b00;
  localparam logic [1:0] c_op_up   = 2'b01;
  localparam logic [1:0] c_op_down = 2'b10;

  // Last prescaler value of a period; the advance opportunity falls here.
  localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_ABRT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PRE_W-1:0] r_pre;
  logic [WIDTH-1:0] r_target;
  logic             r_dir;
  logic [WIDTH-1:0] r_ld_val;

  logic             w_accept;
  logic             w_tick;
  logic             w_match;
  logic             w_run_cmd;

  assign w_tick    = (r_pre == c_pre_max);
  assign w_match   = (cnt_val == r_target);
  assign w_run_cmd = (cmd_op == c_op_up) || (cmd_op == c_op_down);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command capture and prescaler; prescaler sits at 0 outside RUN so every
  // run starts a fresh period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre    <= '0;
      r_target <= '0;
      r_dir    <= 1'b1;
      r_ld_val <= '0;
    end else begin
      if (w_accept) begin
        case (cmd_op)
          c_op_load: r_ld_val <= cmd_arg;
          c_op_up: begin
            r_target <= cmd_arg;
            r_dir    <= 1'b1;
          end
          c_op_down: begin
            r_target <= cmd_arg;
            r_dir    <= 1'b0;
          end
          default: ;
        endcase
      end
      if (r_state == S_RUN) begin
        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      end else begin
        r_pre <= '0;
      end
    end
  end

  // Next-state and output decode; every output is forced idle while rst is
  // high so a mid-run reset emits nothing in its own cycle.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    w_accept    = 1'b0;
    cnt_en      = 1'b0;
    cnt_ld      = 1'b0;
    cnt_dir     = r_dir;
    cnt_ld_val  = r_ld_val;
    busy        = 1'b0;
    done        = 1'b0;
    aborted     = 1'b0;

    case (r_state)
      S_IDLE: begin
        cmd_ready = !rst;
        w_accept  = cmd_valid && !rst;
        if (w_accept) begin
          case (cmd_op)
            c_op_load: w_state_nxt = S_LOAD;
            c_op_up:   w_state_nxt = S_RUN;
            c_op_down: w_state_nxt = S_RUN;
            default:   w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        cnt_ld      = 1'b1;
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        busy   = 1'b1;
        cnt_en = w_tick && !w_match && !abort;
        if (w_match) begin
          w_state_nxt = S_DONE;
        end else if (abort) begin
          w_state_nxt = S_ABRT;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ABRT: begin
        busy        = 1'b1;
        aborted     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (rst) begin
      cnt_en     = 1'b0;
      cnt_ld     = 1'b0;
      cnt_dir    = 1'b1;
      cnt_ld_val = '0;
      busy       = 1'b0;
      done       = 1'b0;
      aborted    = 1'b0;
    end
  end

`ifdef BITCOUNT_CTRL_STEPCNT_EN
  logic [WIDTH:0] r_steps;

  // Advance counter for the most recent run; cleared only on RUN entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_steps <= '0;
    end else if (w_accept && w_run_cmd) begin
      r_steps <= '0;
    end else if (cnt_en) begin
      r_steps <= r_steps + (WIDTH+1)'(1);
    end
  end

  assign steps = r_steps;
`else
  logic w_unused;
  assign w_unused = w_run_cmd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitcount_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitcount_ctrl
// Description : Directed self-checking bench for bitcount_ctrl. Two instances:
//               A with PRESCALE=1, B with PRESCALE=4, each closing the loop
//               through a simple wrapping counter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitcount_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_valid, a_ready, a_abort, a_en, a_dir, a_ld, a_busy, a_done, a_abrt;
  logic [1:0] a_op;
  logic [3:0] a_arg, a_cnt, a_ld_val;
  logic       b_valid, b_ready, b_abort, b_en, b_dir, b_ld, b_busy, b_done, b_abrt;
  logic [1:0] b_op;
  logic [3:0] b_arg, b_cnt, b_ld_val;
`ifdef BITCOUNT_CTRL_STEPCNT_EN
  logic [4:0] a_steps, b_steps;
`endif

  int checks = 0;
  int errors = 0;

  bitcount_ctrl #(.WIDTH(4), .PRESCALE(1), .PRE_W(8)) u_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(a_op), .cmd_arg(a_arg), .abort(a_abort), .cnt_val(a_cnt),
    .cnt_en(a_en), .cnt_dir(a_dir), .cnt_ld(a_ld), .cnt_ld_val(a_ld_val),
    .busy(a_busy), .done(a_done), .aborted(a_abrt)
`ifdef BITCOUNT_CTRL_STEPCNT_EN
    , .steps(a_steps)
`endif
  );

  bitcount_ctrl #(.WIDTH(4), .PRESCALE(4), .PRE_W(8)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_arg(b_arg), .abort(b_abort), .cnt_val(b_cnt),
    .cnt_en(b_en), .cnt_dir(b_dir), .cnt_ld(b_ld), .cnt_ld_val(b_ld_val),
    .busy(b_busy), .done(b_done), .aborted(b_abrt)
`ifdef BITCOUNT_CTRL_STEPCNT_EN
    , .steps(b_steps)
`endif
  );

  // Counter datapath models.
  always_ff @(posedge clk) begin
    if (rst) a_cnt <= 4'd0;
    else if (a_ld) a_cnt <= a_ld_val;
    else if (a_en) a_cnt <= a_dir ? a_cnt + 4'd1 : a_cnt - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) b_cnt <= 4'd0;
    else if (b_ld) b_cnt <= b_ld_val;
    else if (b_en) b_cnt <= b_dir ? b_cnt + 4'd1 : b_cnt - 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command, confirm it is accepted, return at the first cycle
  // of the resulting state.
  task automatic send(input bit sel, input logic [1:0] op, input logic [3:0] arg);
    if (!sel) begin a_valid = 1'b1; a_op = op; a_arg = arg; end
    else      begin b_valid = 1'b1; b_op = op; b_arg = arg; end
    #1 chk("ready_at_send", sel ? b_ready : a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Walk a busy period cycle by cycle (iteration 1 = first cycle after
  // accept), asserting abort on iteration abort_at, and tally outputs.
  int en_n, busy_n, done_n, done_at, abrt_n, bad_n, up_n, timeout;
  logic [31:0] en_mask;
  task automatic measure(input bit sel, input int abort_at);
    en_n = 0; busy_n = 0; done_n = 0; done_at = 0; abrt_n = 0;
    bad_n = 0; up_n = 0; en_mask = 0; timeout = 1;
    for (int i = 1; i <= 100; i++) begin
      a_abort = !sel && (i == abort_at);
      b_abort =  sel && (i == abort_at);
      #1;
      if (!(sel ? b_busy : a_busy)) begin
        timeout = 0;
        break;
      end
      busy_n++;
      if (sel ? b_en : a_en) begin
        en_n++;
        en_mask[i] = 1'b1;
        if (sel ? b_dir : a_dir) up_n++;
      end
      if (sel ? b_done : a_done) begin done_n++; done_at = i; end
      if (sel ? b_abrt : a_abrt) abrt_n++;
      if (sel ? (b_en && b_ld) : (a_en && a_ld)) bad_n++;
      if (sel ? b_ready : a_ready) bad_n++;
      @(negedge clk);
    end
    a_abort = 1'b0;
    b_abort = 1'b0;
    chk("timeout", timeout, 0);
    chk("exclusive_ready", bad_n, 0);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_op = 0; a_arg = 0; a_abort = 0;
    b_valid = 0; b_op = 0; b_arg = 0; b_abort = 0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_dir", a_dir, 1);
    chk("rst_outs", {a_en, a_ld, a_done, a_abrt, a_ld_val}, 0);
`ifdef BITCOUNT_CTRL_STEPCNT_EN
    chk("rst_steps", a_steps, 0);
`endif
    rst = 1'b0;
    #1 chk("ready_after_rst", a_ready, 1);

    // LOAD 9: one cnt_ld cycle, ready again 2 cycles after accept.
    send(0, 2'b00, 4'd9);
    #1;
    chk("load_ld", a_ld, 1);
    chk("load_val", a_ld_val, 9);
    chk("load_ready", a_ready, 0);
    chk("load_en", a_en, 0);
    @(negedge clk); #1;
    chk("load_ld_off", a_ld, 0);
    chk("load_ready_back", a_ready, 1);
    chk("load_cnt", a_cnt, 9);

    // 3 -> RUN_UP 7.
    send(0, 2'b00, 4'd3); @(negedge clk);
    send(0, 2'b01, 4'd7);
    measure(0, 0);
    chk("up_en_n", en_n, 4);
    chk("up_en_mask", en_mask, 32'h1E);
    chk("up_busy_n", busy_n, 6);
    chk("up_done_n", done_n, 1);
    chk("up_done_at", done_at, 6);
    chk("up_abrt_n", abrt_n, 0);
    chk("up_cnt", a_cnt, 7);
`ifdef BITCOUNT_CTRL_STEPCNT_EN
    chk("up_steps", a_steps, 4);
`endif

    // Wrap: 14 -> RUN_UP 1.
    send(0, 2'b00, 4'd14); @(negedge clk);
    send(0, 2'b01, 4'd1);
    measure(0, 0);
    chk("wrap_en_n", en_n, 3);
    chk("wrap_done_n", done_n, 1);
    chk("wrap_busy_n", busy_n, 5);
    chk("wrap_cnt", a_cnt, 1);

    // PRESCALE=4: 5 -> RUN_DOWN 3.
    send(1, 2'b00, 4'd5); @(negedge clk);
    send(1, 2'b10, 4'd3);
    measure(1, 0);
    chk("pre_en_mask", en_mask, 32'h110);
    chk("pre_up_n", up_n, 0);
    chk("pre_done_at", done_at, 10);
    chk("pre_done_n", done_n, 1);
    chk("pre_cnt", b_cnt, 3);
    chk("pre_dir_hold", b_dir, 0);

    // Abort on 3rd RUN cycle of 0 -> RUN_UP 15.
    send(0, 2'b00, 4'd0); @(negedge clk);
    send(0, 2'b01, 4'd15);
    measure(0, 3);
    chk("abrt_en_mask", en_mask, 32'h6);
    chk("abrt_abrt_n", abrt_n, 1);
    chk("abrt_done_n", done_n, 0);
    chk("abrt_busy_n", busy_n, 4);
    chk("abrt_cnt", a_cnt, 2);
`ifdef BITCOUNT_CTRL_STEPCNT_EN
    chk("abrt_steps", a_steps, 2);
`endif

    // Target already reached: zero advances, done 2 cycles after accept.
    send(0, 2'b00, 4'd6); @(negedge clk);
`ifdef BITCOUNT_CTRL_STEPCNT_EN
    chk("steps_hold_load", a_steps, 2);
`endif
    send(0, 2'b01, 4'd6);
    measure(0, 0);
    chk("zero_en_n", en_n, 0);
    chk("zero_done_at", done_at, 2);
    chk("zero_busy_n", busy_n, 2);

    // Abort together with a target match: DONE wins.
    send(0, 2'b01, 4'd6);
    measure(0, 1);
    chk("tie_done_n", done_n, 1);
    chk("tie_abrt_n", abrt_n, 0);

    // NOP is accepted without effect.
    send(0, 2'b11, 4'd3);
    #1;
    chk("nop_busy", a_busy, 0);
    chk("nop_ready", a_ready, 1);
    chk("nop_cnt", a_cnt, 6);

    // RUN_DOWN 6 -> 4, direction held afterwards; a LOAD presented mid-run
    // stays pending until IDLE.
    send(0, 2'b10, 4'd4);
    a_valid = 1'b1; a_op = 2'b00; a_arg = 4'd9;
    measure(0, 0);
    chk("dn_en_n", en_n, 2);
    chk("dn_up_n", up_n, 0);
    chk("dn_cnt", a_cnt, 4);
    chk("dn_dir_hold", a_dir, 0);
    chk("pend_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("pend_ld", a_ld, 1);
    chk("pend_ld_val", a_ld_val, 9);
    chk("pend_dir_hold", a_dir, 0);
    @(negedge clk);

    // Reset mid-RUN: 9 -> RUN_UP 2, rst on 2nd RUN cycle.
    send(0, 2'b01, 4'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_en", a_en, 0);
    chk("mrst_ready", a_ready, 0);
    chk("mrst_pulses", {a_done, a_abrt}, 0);
    @(negedge clk); #1;
    chk("mrst_busy", a_busy, 0);
    chk("mrst_ready2", a_ready, 0);
    chk("mrst_dir", a_dir, 1);
    chk("mrst_pulses2", {a_done, a_abrt, a_en}, 0);
    rst = 1'b0;
    #1 chk("mrst_ready_back", a_ready, 1);
    @(negedge clk); #1;
    chk("mrst_idle", {a_busy, a_done, a_abrt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
